uop_decode_rename: RTL and testbench

//  WIDTH-wide decode + physical-register allocate stage; next generation of the 2-wide decode stage.

---
 rtl/uop_pkg.sv | 58 +++++
 rtl/instruction_decoder.sv | 37 +++
 rtl/preg_freelist.sv | 123 ++++++++++++
 rtl/preg_freelist_chk.sv | 15 +
 rtl/uop_decode_rename.sv | 130 +++++++++++++
 tb/tb_uop_decode_rename.sv | 276 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/uop_pkg.sv
// Shared types for the decode/rename slice: fetch/decode encodings and freelist geometry.
// Consumers honour the UOP_CKPT_EN build macro for branch checkpoint support.
package uop_pkg;

   localparam int NUM_PREGS_DEF = 64;
   localparam int NUM_AREGS_DEF = 32;
   localparam int PREG_W        = $clog2(NUM_PREGS_DEF);
   localparam int FL_DEPTH      = NUM_PREGS_DEF - NUM_AREGS_DEF;
   localparam int CNT_W         = $clog2(FL_DEPTH + 1);
   localparam int FETCH_W       = 32;
   localparam int DEC_W         = 32;

   typedef logic [PREG_W-1:0]          preg_t;
   typedef logic [$clog2(FL_DEPTH):0]  fl_ptr_t;
   typedef fl_ptr_t                    ckpt_slot_t;

   typedef enum logic [6:0] {
      OP_NOP    = 7'd0,
      OP_ALU    = 7'd1,
      OP_LOAD   = 7'd2,
      OP_STORE  = 7'd3,
      OP_BRANCH = 7'd4,
      OP_FENCE  = 7'd5
   } opcode_e;

   typedef enum logic [1:0] {
      RS_NONE = 2'd0,
      RS_ALU  = 2'd1,
      RS_MEM  = 2'd2,
      RS_BR   = 2'd3
   } rs_station_e;

   typedef struct packed {
      opcode_e     opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [9:0]  imm;
   } fetched_instruction_t;

   typedef struct packed {
      logic        is_noop;
      rs_station_e rs_station;
      logic [3:0]  alu_op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [9:0]  imm;
   } decoded_instruction_t;

   // A lane consumes a physical register when it is real work bound for a station.
   function automatic logic lane_needs_preg(logic [DEC_W-1:0] raw);
      decoded_instruction_t d;
      d = decoded_instruction_t'(raw);
      return !d.is_noop && (d.rs_station != RS_NONE);
   endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Single-lane combinational decoder: fetched word to decoded micro-op fields.
module instruction_decoder
   import uop_pkg::*;
(
   input  logic [FETCH_W-1:0] instr,
   output logic [DEC_W-1:0]   decoded
);

   fetched_instruction_t f_s;
   decoded_instruction_t d_s;

   assign f_s = fetched_instruction_t'(instr);

   // Unknown opcodes are squashed to no-ops so they never consume a register.
   always_comb begin
      d_s     = '0;
      d_s.rd  = f_s.rd;
      d_s.rs1 = f_s.rs1;
      d_s.rs2 = f_s.rs2;
      d_s.imm = f_s.imm;
      case (f_s.opcode)
         OP_NOP:    d_s.is_noop = 1'b1;
         OP_ALU: begin
            d_s.rs_station = RS_ALU;
            d_s.alu_op     = f_s.imm[3:0];
         end
         OP_LOAD:   d_s.rs_station = RS_MEM;
         OP_STORE:  d_s.rs_station = RS_MEM;
         OP_BRANCH: d_s.rs_station = RS_BR;
         OP_FENCE:  d_s.rs_station = RS_NONE;
         default:   d_s.is_noop = 1'b1;
      endcase
   end

   assign decoded = d_s;

endmodule

// File: rtl/preg_freelist.sv
// FIFO freelist of physical registers with multi-pop from head and multi-push at tail.
// With UOP_CKPT_EN defined, head pointers can be checkpointed and restored per branch tag.
module preg_freelist
   import uop_pkg::*;
#(
`ifdef UOP_CKPT_EN
   parameter int CKPT_DEPTH    = 4,
`endif
   parameter int WIDTH         = 2,
   parameter int RELEASE_WIDTH = 2,
   parameter int NUM_PREGS     = NUM_PREGS_DEF,
   parameter int NUM_AREGS     = NUM_AREGS_DEF,
   localparam int PREG_BITS    = $clog2(NUM_PREGS),
   localparam int FL_SIZE      = NUM_PREGS - NUM_AREGS,
   localparam int IDX_W        = $clog2(FL_SIZE),
   localparam int PTR_W        = IDX_W + 1,
   localparam int FREE_BITS    = $clog2(FL_SIZE + 1),
   localparam int NA_W         = $clog2(WIDTH + 1)
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [NA_W-1:0]                    pop_n,
   output logic [WIDTH*PREG_BITS-1:0]         head_preg,
   input  logic [RELEASE_WIDTH-1:0]           release_valid,
   input  logic [RELEASE_WIDTH*PREG_BITS-1:0] release_preg,
`ifdef UOP_CKPT_EN
   input  logic                               ckpt_valid,
   input  logic [$clog2(CKPT_DEPTH)-1:0]      ckpt_tag,
   input  logic                               restore_valid,
   input  logic [$clog2(CKPT_DEPTH)-1:0]      restore_tag,
`endif
   output logic [FREE_BITS-1:0]               num_free
);

   logic [PREG_BITS-1:0]     mem_r [FL_SIZE];
   logic [PTR_W-1:0]         head_r;
   logic [PTR_W-1:0]         tail_r;
   logic [PTR_W-1:0]         head_next_s;
   logic [PTR_W-1:0]         tail_next_s;
   logic [PTR_W-1:0]         room_s;
   logic [PTR_W-1:0]         push_cnt_s;
   logic [RELEASE_WIDTH-1:0] push_en_s;
   logic [IDX_W-1:0]         push_idx_s [RELEASE_WIDTH];

`ifdef UOP_CKPT_EN
   logic [PTR_W-1:0]         ckpt_r [CKPT_DEPTH];
`endif

   // Present the WIDTH oldest free registers; the caller decides how many it takes.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         head_preg[i*PREG_BITS +: PREG_BITS] = mem_r[IDX_W'(head_r + PTR_W'(i))];
      end
   end

   // Head advance (or rewind), then pack valid releases into the room left after it.
   always_comb begin
      head_next_s = head_r + PTR_W'(pop_n);
`ifdef UOP_CKPT_EN
      if (restore_valid) begin
         head_next_s = ckpt_r[restore_tag];
      end else begin
         head_next_s = head_r + PTR_W'(pop_n);
      end
`endif
      room_s     = PTR_W'(FL_SIZE) - (tail_r - head_next_s);
      push_cnt_s = '0;
      for (int j = 0; j < RELEASE_WIDTH; j++) begin
         push_idx_s[j] = IDX_W'(tail_r + push_cnt_s);
         if (release_valid[j] && (push_cnt_s < room_s)) begin
            push_en_s[j] = 1'b1;
            push_cnt_s   = push_cnt_s + PTR_W'(1);
         end else begin
            push_en_s[j] = 1'b0;
         end
      end
      tail_next_s = tail_r + push_cnt_s;
   end

   // Pointer and storage update; reset loads every non-architectural register in order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_r <= '0;
         tail_r <= PTR_W'(FL_SIZE);
         for (int i = 0; i < FL_SIZE; i++) begin
            mem_r[i] <= PREG_BITS'(NUM_AREGS + i);
         end
      end else begin
         head_r <= head_next_s;
         tail_r <= tail_next_s;
         for (int j = 0; j < RELEASE_WIDTH; j++) begin
            if (push_en_s[j]) begin
               mem_r[push_idx_s[j]] <= release_preg[j*PREG_BITS +: PREG_BITS];
            end
         end
      end
   end

`ifdef UOP_CKPT_EN
   // Snapshot the post-allocation head; a restore in the same cycle takes precedence.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < CKPT_DEPTH; i++) begin
            ckpt_r[i] <= '0;
         end
      end else if (ckpt_valid && !restore_valid) begin
         ckpt_r[ckpt_tag] <= head_r + PTR_W'(pop_n);
      end
   end
`endif

   assign num_free = FREE_BITS'(tail_r - head_r);

   preg_freelist_chk #(
      .RELEASE_WIDTH (RELEASE_WIDTH)
   ) u_chk (
      .clk           (clk),
      .reset_n       (reset_n),
      .release_valid (release_valid),
      .push_en       (push_en_s)
   );

endmodule

// File: rtl/preg_freelist_chk.sv
// Property checker for the physical-register freelist.
module preg_freelist_chk #(
   parameter int RELEASE_WIDTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [RELEASE_WIDTH-1:0] release_valid,
   input  logic [RELEASE_WIDTH-1:0] push_en
);

   // Every committed release must find room; a dropped one leaks a register.
   a_no_release_drop: assert property (@(posedge clk) disable iff (!reset_n)
      ((release_valid & ~push_en) == '0));

endmodule

// File: rtl/uop_decode_rename.sv
// WIDTH-wide decode and physical-register allocation stage with a registered output group.
// Define UOP_CKPT_EN to add branch checkpoint/restore ports on the freelist head.
module uop_decode_rename
   import uop_pkg::*;
#(
`ifdef UOP_CKPT_EN
   parameter int CKPT_DEPTH    = 4,
`endif
   parameter int WIDTH         = 2,
   parameter int NUM_PREGS     = NUM_PREGS_DEF,
   parameter int NUM_AREGS     = NUM_AREGS_DEF,
   parameter int RELEASE_WIDTH = 2,
   localparam int PREG_BITS    = $clog2(NUM_PREGS),
   localparam int FREE_BITS    = $clog2(NUM_PREGS - NUM_AREGS + 1),
   localparam int NA_W         = $clog2(WIDTH + 1)
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               clear,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [WIDTH*FETCH_W-1:0]           instr,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [WIDTH*DEC_W-1:0]             decoded,
   output logic [WIDTH*PREG_BITS-1:0]         preg,
   output logic [WIDTH-1:0]                   alloc_mask,
   output logic [NA_W-1:0]                    num_alloc,
   output logic [FREE_BITS-1:0]               num_free,
   input  logic [RELEASE_WIDTH-1:0]           release_valid,
   input  logic [RELEASE_WIDTH*PREG_BITS-1:0] release_preg
`ifdef UOP_CKPT_EN
   ,
   input  logic                               ckpt_valid,
   input  logic [$clog2(CKPT_DEPTH)-1:0]      ckpt_tag,
   input  logic                               restore_valid,
   input  logic [$clog2(CKPT_DEPTH)-1:0]      restore_tag
`endif
);

   logic [WIDTH*DEC_W-1:0]     dec_s;
   logic [WIDTH*PREG_BITS-1:0] head_preg_s;
   logic [WIDTH*PREG_BITS-1:0] grant_preg_s;
   logic [WIDTH-1:0]           grant_mask_s;
   logic [NA_W-1:0]            need_s;
   logic [NA_W-1:0]            pop_n_s;
   logic                       accept_s;
   logic                       restore_s;

   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      instruction_decoder u_dec (
         .instr   (instr[g*FETCH_W +: FETCH_W]),
         .decoded (dec_s[g*DEC_W +: DEC_W])
      );
   end

   // Needing lanes take successive freelist entries in ascending lane order.
   always_comb begin
      need_s       = '0;
      grant_mask_s = '0;
      grant_preg_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (lane_needs_preg(dec_s[i*DEC_W +: DEC_W])) begin
            grant_mask_s[i]                        = 1'b1;
            grant_preg_s[i*PREG_BITS +: PREG_BITS] = head_preg_s[need_s*PREG_BITS +: PREG_BITS];
            need_s                                 = need_s + NA_W'(1);
         end else begin
            grant_mask_s[i] = 1'b0;
         end
      end
   end

`ifdef UOP_CKPT_EN
   assign restore_s = restore_valid;
`else
   assign restore_s = 1'b0;
`endif

   // Whole group or nothing; occupancy seen here excludes this cycle's releases.
   assign in_ready = !clear && !restore_s && (!out_valid || out_ready)
                     && (num_free >= FREE_BITS'(need_s));
   assign accept_s = in_valid && in_ready;
   assign pop_n_s  = accept_s ? need_s : '0;

   // Output group register; held while downstream stalls.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         decoded    <= '0;
         preg       <= '0;
         alloc_mask <= '0;
         num_alloc  <= '0;
      end else if (clear) begin
         out_valid <= 1'b0;
      end else if (accept_s) begin
         out_valid  <= 1'b1;
         decoded    <= dec_s;
         preg       <= grant_preg_s;
         alloc_mask <= grant_mask_s;
         num_alloc  <= need_s;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   preg_freelist #(
`ifdef UOP_CKPT_EN
      .CKPT_DEPTH    (CKPT_DEPTH),
`endif
      .WIDTH         (WIDTH),
      .RELEASE_WIDTH (RELEASE_WIDTH),
      .NUM_PREGS     (NUM_PREGS),
      .NUM_AREGS     (NUM_AREGS)
   ) u_freelist (
      .clk           (clk),
      .reset_n       (reset_n),
      .pop_n         (pop_n_s),
      .head_preg     (head_preg_s),
      .release_valid (release_valid),
      .release_preg  (release_preg),
`ifdef UOP_CKPT_EN
      .ckpt_valid    (ckpt_valid && accept_s),
      .ckpt_tag      (ckpt_tag),
      .restore_valid (restore_valid),
      .restore_tag   (restore_tag),
`endif
      .num_free      (num_free)
   );

endmodule

// File: tb/tb_uop_decode_rename.sv
// Bench for uop_decode_rename (WIDTH=2): freelist model with absolute indices plus directed checks.
module tb_uop_decode_rename;

   localparam int W  = 2;
   localparam int RW = 2;
   localparam int PB = 6;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            clear = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W*32-1:0] instr = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [W*32-1:0] decoded;
   logic [W*PB-1:0] preg;
   logic [W-1:0]    alloc_mask;
   logic [1:0]      num_alloc;
   logic [5:0]      num_free;
   logic [RW-1:0]   release_valid = '0;
   logic [RW*PB-1:0] release_preg = '0;
   logic            ckpt_valid = 1'b0;
   logic [1:0]      ckpt_tag = '0;
   logic            restore_valid = 1'b0;
   logic [1:0]      restore_tag = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uop_decode_rename dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .clear         (clear),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .instr         (instr),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .decoded       (decoded),
      .preg          (preg),
      .alloc_mask    (alloc_mask),
      .num_alloc     (num_alloc),
      .num_free      (num_free),
      .release_valid (release_valid),
      .release_preg  (release_preg)
`ifdef UOP_CKPT_EN
      ,
      .ckpt_valid    (ckpt_valid),
      .ckpt_tag      (ckpt_tag),
      .restore_valid (restore_valid),
      .restore_tag   (restore_tag)
`endif
   );

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Fetch word: opcode[31:25] rd[24:20] rs1[19:15] rs2[14:10] imm[9:0].
   function automatic logic [31:0] mk(int op, int rd);
      return {7'(op), 5'(rd), 5'd1, 5'd2, 10'(rd * 3 + 1)};
   endfunction

   function automatic bit lane_need(logic [31:0] w);
      int op;
      op = int'(w[31:25]);
      return (op >= 1) && (op <= 4);
   endfunction

   // Decoded word: is_noop, station[1:0], alu_op[3:0], then rd/rs1/rs2/imm unchanged.
   function automatic logic [31:0] exp_dec(logic [31:0] w);
      int op;
      logic noop;
      logic [1:0] st;
      logic [3:0] aop;
      op = int'(w[31:25]);
      noop = 1'b0; st = 2'd0; aop = 4'd0;
      if (op == 0 || op > 5) noop = 1'b1;
      else if (op == 1) begin st = 2'd1; aop = w[3:0]; end
      else if (op == 2 || op == 3) st = 2'd2;
      else if (op == 4) st = 2'd3;
      return {noop, st, aop, w[24:0]};
   endfunction

   // Model: free registers are hist[m_head .. m_tail-1], indices never wrap.
   int hist [0:4095];
   int m_head, m_tail;
   int ck [0:3];
   bit m_init = 1'b0;
   bit m_ov;
   logic [W*PB-1:0] e_preg;
   logic [W-1:0]    e_mask;
   int              e_nalloc;
   logic [W*32-1:0] e_dec;

   function automatic bit m_in_ready();
      int need;
      need = 0;
      for (int i = 0; i < W; i++) if (lane_need(instr[i*32 +: 32])) need++;
      return !clear && !restore_valid && (!m_ov || out_ready) && ((m_tail - m_head) >= need);
   endfunction

   always @(posedge clk) begin : model
      bit acc;
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) hist[i] = 32 + i;
         m_head = 0; m_tail = 32; m_ov = 1'b0;
         e_preg = '0; e_mask = '0; e_nalloc = 0; e_dec = '0;
         for (int i = 0; i < 4; i++) ck[i] = 0;
         m_init = 1'b1;
      end else begin
         acc = in_valid && m_in_ready();
`ifdef UOP_CKPT_EN
         if (restore_valid) m_head = ck[restore_tag];
`endif
         if (acc) begin
            e_preg = '0; e_mask = '0; e_nalloc = 0;
            for (int i = 0; i < W; i++) begin
               e_dec[i*32 +: 32] = exp_dec(instr[i*32 +: 32]);
               if (lane_need(instr[i*32 +: 32])) begin
                  e_mask[i] = 1'b1;
                  e_preg[i*PB +: PB] = PB'(hist[m_head]);
                  m_head++;
                  e_nalloc++;
               end
            end
            m_ov = 1'b1;
`ifdef UOP_CKPT_EN
            if (ckpt_valid) ck[ckpt_tag] = m_head;
`endif
         end else if (clear || out_ready) begin
            m_ov = 1'b0;
         end
         for (int j = 0; j < RW; j++) begin
            if (release_valid[j]) begin
               hist[m_tail] = int'(release_preg[j*PB +: PB]);
               m_tail++;
            end
         end
      end
   end

   // Compare DUT against the model mid-cycle.
   always @(negedge clk) begin
      if (m_init) begin
         chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
         chk("out_valid", 64'(out_valid), 64'(m_ov));
         chk("num_free", 64'(num_free), 64'(m_tail - m_head));
         if (m_ov) begin
            chk("preg", 64'(preg), 64'(e_preg));
            chk("alloc_mask", 64'(alloc_mask), 64'(e_mask));
            chk("num_alloc", 64'(num_alloc), 64'(e_nalloc));
            chk("decoded", 64'(decoded), 64'(e_dec));
         end
      end
   end

   task automatic drive(logic v, logic [31:0] l0, logic [31:0] l1, logic ordy);
      in_valid  = v;
      instr     = {l1, l0};
      out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      release_valid = '0;
      ckpt_valid    = 1'b0;
      restore_valid = 1'b0;
      clear         = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      reset_n = 1'b1;
      chk("rst_num_free", 64'(num_free), 64'd32);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_alloc_mask", 64'(alloc_mask), 64'd0);

      drive(1'b1, mk(1, 3), mk(1, 4), 1'b1);
`ifdef UOP_CKPT_EN
      ckpt_valid = 1'b1; ckpt_tag = 2'd1;
`endif
      tick();
      chk("first_preg", 64'(preg), 64'({6'd33, 6'd32}));
      chk("first_free", 64'(num_free), 64'd30);
      chk("first_nalloc", 64'(num_alloc), 64'd2);

      drive(1'b1, mk(0, 0), mk(1, 5), 1'b1);
      tick();
      chk("noop_mask", 64'(alloc_mask), 64'(2'b10));
      chk("noop_preg", 64'(preg), 64'({6'd34, 6'd0}));
      chk("noop_nalloc", 64'(num_alloc), 64'd1);

      drive(1'b1, mk(2, 6), mk(4, 7), 1'b0);
      #1 chk("stall_ready0", 64'(in_ready), 64'd0);
      tick();
      chk("stall_hold1", 64'(preg), 64'({6'd34, 6'd0}));
      #1 chk("stall_ready1", 64'(in_ready), 64'd0);
      tick();
      chk("stall_hold2", 64'(alloc_mask), 64'(2'b10));
      chk("stall_free", 64'(num_free), 64'd29);
      out_ready = 1'b1;
      #1 chk("stall_release", 64'(in_ready), 64'd1);
      tick();
      chk("ldbr_preg", 64'(preg), 64'({6'd36, 6'd35}));

      drive(1'b1, mk(1, 8), mk(5, 9), 1'b1);
      clear = 1'b1;
      #1 chk("clear_ready", 64'(in_ready), 64'd0);
      tick();
      chk("clear_ov", 64'(out_valid), 64'd0);
      drive(1'b1, mk(5, 1), mk(3, 2), 1'b1);
      tick();
      chk("fence_mask", 64'(alloc_mask), 64'(2'b10));
      chk("fence_preg", 64'(preg), 64'({6'd37, 6'd0}));

`ifdef UOP_CKPT_EN
      drive(1'b1, mk(1, 10), mk(1, 11), 1'b1);
      restore_valid = 1'b1; restore_tag = 2'd1;
      #1 chk("restore_ready", 64'(in_ready), 64'd0);
      tick();
      chk("restore_free", 64'(num_free), 64'd30);
      tick();
      chk("restore_preg", 64'(preg), 64'({6'd35, 6'd34}));
`endif

      for (int n = 0; n < 40 && (m_tail - m_head) > 1; n++) begin
         if ((m_tail - m_head) >= 3) drive(1'b1, mk(1, 12), mk(2, 13), 1'b1);
         else drive(1'b1, mk(0, 0), mk(1, 14), 1'b1);
         tick();
      end
      drive(1'b1, mk(1, 15), mk(1, 16), 1'b1);
      #1 chk("short_ready", 64'(in_ready), 64'd0);
      chk("short_free", 64'(num_free), 64'd1);
      release_valid = 2'b01; release_preg = {6'd0, 6'd5};
      #1 chk("short_prerel", 64'(in_ready), 64'd0);
      tick();
      #1 chk("short_after", 64'(in_ready), 64'd1);
      tick();
      chk("wrap_preg", 64'(preg), 64'({6'd5, 6'd63}));
      chk("wrap_free", 64'(num_free), 64'd0);

      drive(1'b0, mk(0, 0), mk(0, 0), 1'b1);
      release_valid = 2'b11; release_preg = {6'd9, 6'd7};
      tick();
      chk("rel2_free", 64'(num_free), 64'd2);
      drive(1'b1, mk(1, 17), mk(1, 18), 1'b1);
      release_valid = 2'b11; release_preg = {6'd12, 6'd11};
      tick();
      chk("accrel_preg", 64'(preg), 64'({6'd9, 6'd7}));
      chk("accrel_free", 64'(num_free), 64'd2);
      tick();
      chk("emerge_preg", 64'(preg), 64'({6'd12, 6'd11}));
      chk("emerge_free", 64'(num_free), 64'd0);
      drive(1'b0, mk(0, 0), mk(0, 0), 1'b1);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
